// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- nibble-serial 32-bit ALU with valid/ready request and response.
//
// An operation is accepted in IDLE, then processed 4 bits per clock (LSB
// slice first, carry registered between slices) for 8 cycles in BUSY. The
// result and flags are presented in DONE until the initiator takes them.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   initiator presents an operation
//   req_ready  out  high only in IDLE
//   a, b       in   32-bit operands
//   cmd        in   0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
//   rsp_valid  out  high only in DONE
//   rsp_ready  in   initiator consumes the result (only looked at in DONE)
//   res        out  32-bit result
//   cout       out  carry out of bit 31 (ADD/SUB only, else 0)
//   ofl        out  signed overflow (ADD/SUB only, else 0)
//   zero       out  final result equals zero
//   op_count   out  16-bit count of completed handshakes, wraps; present only
//                   when the macro ALU_SEQ_OPCOUNT_EN is defined
// -----------------------------------------------------------------------------
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] res,
  output logic        cout,
  output logic        ofl,
  output logic        zero
`ifdef ALU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_t;

  state_t      r_state;
  state_t      w_next_state;

  cmd_t        r_cmd;
  logic [31:0] r_a;       // shifts right one nibble per BUSY cycle
  logic [31:0] r_b;       // stored pre-inverted for SUB/SLT
  logic        r_carry;   // carry into the current slice
  logic [2:0]  r_cnt;     // slice index 0..7
  logic [27:0] r_sum;     // slices 0..6, shifted in from the top

  logic [31:0] r_res;
  logic        r_cout;
  logic        r_ofl;
  logic        r_zero;

  logic        w_accept;
  logic        w_last;
  logic        w_release;
  logic        w_sub_like;
  logic        w_addsub;
  logic [4:0]  w_sum5;
  logic [3:0]  w_slice;
  logic        w_c31;
  logic        w_ofl;
  logic [31:0] w_final_res;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_last    = (r_state == ST_BUSY) && (r_cnt == 3'd7);
  assign w_release = (r_state == ST_DONE) && rsp_ready;

  // SUB and SLT both run a + ~b + 1; decided from the raw cmd at capture.
  assign w_sub_like = (cmd == 3'(CMD_SUB)) || (cmd == 3'(CMD_SLT));
  assign w_addsub   = (r_cmd == CMD_ADD) || (r_cmd == CMD_SUB);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_next_state = ST_BUSY;
      ST_BUSY: if (w_last)    w_next_state = ST_DONE;
      ST_DONE: if (w_release) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);

  // ---------------------------------------------------------------------------
  // Slice datapath: always works on the low nibble of the shifting operands.
  // ---------------------------------------------------------------------------
  assign w_sum5 = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_carry};

  always_comb begin
    w_slice = w_sum5[3:0];
    case (r_cmd)
      CMD_XOR:  w_slice = r_a[3:0] ^ r_b[3:0];
      CMD_AND:  w_slice = r_a[3:0] & r_b[3:0];
      CMD_NAND: w_slice = ~(r_a[3:0] & r_b[3:0]);
      CMD_NOR:  w_slice = ~(r_a[3:0] | r_b[3:0]);
      CMD_OR:   w_slice = r_a[3:0] | r_b[3:0];
      default:  w_slice = w_sum5[3:0];
    endcase
  end

  // On the top slice, the carry into bit 31 is recovered from that bit's own
  // sum: s = a ^ b ^ cin, hence cin = a ^ b ^ s.
  assign w_c31 = r_a[3] ^ r_b[3] ^ w_sum5[3];
  assign w_ofl = w_c31 ^ w_sum5[4];

  assign w_final_res = (r_cmd == CMD_SLT) ? {31'd0, w_sum5[3] ^ w_ofl}
                                          : {w_slice, r_sum};

  // NOTE: the operand and result registers are reset along with the control
  // state because the reset value of res/flags is visible at the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= CMD_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ofl   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_cmd   <= cmd_t'(cmd);
      r_a     <= a;
      r_b     <= w_sub_like ? ~b : b;
      r_carry <= w_sub_like;
      r_cnt   <= '0;
    end else if (r_state == ST_BUSY) begin
      r_a     <= {4'd0, r_a[31:4]};
      r_b     <= {4'd0, r_b[31:4]};
      r_carry <= w_sum5[4];
      r_sum   <= {w_slice, r_sum[27:4]};
      // Counter parks at 7; leaving BUSY prevents a ninth slice.
      if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_res  <= w_final_res;
        r_cout <= w_addsub ? w_sum5[4] : 1'b0;
        r_ofl  <= w_addsub ? w_ofl : 1'b0;
        r_zero <= (w_final_res == 32'd0);
      end
    end
  end

  assign res  = r_res;
  assign cout = r_cout;
  assign ofl  = r_ofl;
  assign zero = r_zero;

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] r_op_count;

  // Wraps naturally from 16'hFFFF to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_op_count <= '0;
    else if (w_release) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  cmd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] res;
  logic        cout;
  logic        ofl;
  logic        zero;
`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt = '0;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .cmd       (cmd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .res       (res),
    .cout      (cout),
    .ofl       (ofl),
    .zero      (zero)
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the command definitions.
  function automatic void model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic co, output logic ov);
    logic [32:0] s;
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (c)
      3'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[31:0];
        co = s[32];
        ov = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'd1: begin
        s  = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'd2: r = x ^ y;
      3'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    logic [31:0] er;
    logic        eco;
    logic        eov;
    model(c, x, y, er, eco, eov);

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    a = x; b = y; cmd = c; req_valid = 1'b1;
    rsp_ready = 1'b1;  // ignored outside DONE
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not matter.
    req_valid = 1'($urandom_range(0, 1));
    a = $urandom; b = $urandom; cmd = 3'($urandom);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("rsp_valid_at8", 32'(rsp_valid), 32'd1);
    chk("res",  res, er);
    chk("cout", 32'(cout), 32'(eco));
    chk("ofl",  32'(ofl),  32'(eov));
    chk("zero", 32'(zero), 32'(er == 32'd0));

    req_valid = 1'b1;  // second request while DONE must be ignored
    rsp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_res", res, er);
`ifdef ALU_SEQ_OPCOUNT_EN
      chk("hold_op_count", 32'(op_count), 32'(exp_cnt));
`endif
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
`ifdef ALU_SEQ_OPCOUNT_EN
    chk("op_count", 32'(op_count), 32'(exp_cnt));
`endif
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    a = '0; b = '0; cmd = '0;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_res",  res, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ofl",  32'(ofl),  32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
`ifdef ALU_SEQ_OPCOUNT_EN
    chk("rst_op_count", 32'(op_count), 32'd0);
`endif

    // Release between edges so do_op requests on the very first rising edge.
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed vectors
    do_op(3'd0, 32'd0, 32'd0, 0);
    chk("add00_zero_lit", 32'(zero), 32'd1);
    do_op(3'd0, 32'd72738, 32'hFFFFFF83, 1);
    chk("add_vec_lit", res, 32'h00011BA5);
    chk("add_vec_cout_lit", 32'(cout), 32'd1);
    do_op(3'd1, 32'd2, 32'd1, 0);
    chk("sub_vec_lit", res, 32'd1);
    do_op(3'd1, 32'h80000000, 32'd1, 2);
    chk("sub_ofl_lit", 32'(ofl), 32'd1);
    do_op(3'd3, 32'hFFFFFFFF, 32'd1, 0);
    chk("slt_neg_lit", res, 32'd1);
    do_op(3'd3, 32'd5, 32'd5, 5);
    chk("slt_eq_zero_lit", 32'(zero), 32'd1);
    do_op(3'd0, 32'h7FFFFFFF, 32'd1, 0);
    do_op(3'd1, 32'h12345678, 32'd0, 0);
    do_op(3'd3, 32'h7FFFFFFF, 32'h80000000, 0);
    do_op(3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
    do_op(3'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    do_op(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    do_op(3'd6, 32'h00000000, 32'h00000000, 0);
    do_op(3'd7, 32'h80000001, 32'h00F00000, 0);

    // Reset in the middle of BUSY (slice 4 about to be processed)
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; cmd = 3'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_res",  res, 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ofl",  32'(ofl),  32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
`ifdef ALU_SEQ_OPCOUNT_EN
    chk("midrst_op_count", 32'(op_count), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  c;
      x = $urandom;
      y = (n % 6 == 0) ? x : $urandom;
      c = 3'($urandom_range(0, 7));
      do_op(c, x, y, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
